// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction field positions, opcode constants, fetch FSM states.
// Pure declarations; no latency or backpressure of its own.
// Field accessors keep bit positions in one place for fetch and decode.
package mips_pkg;

    localparam int INSTR_W    = 32;
    localparam int IMM_W      = 16;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        HALT = 2'd3
    } ifu_state_t;

    function automatic logic [5:0] get_opcode(input logic [INSTR_W-1:0] i);
        return i[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [5:0] get_funct(input logic [INSTR_W-1:0] i);
        return i[FUNCT_MSB:FUNCT_LSB];
    endfunction

    function automatic logic [IMM_W-1:0] get_imm(input logic [INSTR_W-1:0] i);
        return i[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC select: jr target (word aligned) > taken beq (pc+4+sext(imm)<<2) > pc+4.
// Purely combinational, zero latency; no backpressure.
// All arithmetic wraps modulo 2^ADDR_W.
import mips_pkg::*;

module pc_next_logic #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [IMM_W-1:0]  imm,
    input  logic              branch,
    input  logic              zero,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jr_aligned;

    always_comb begin
        pc_plus4   = pc + ADDR_W'(4);
        br_off     = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm} << 2;
        // Low target bits are dropped here; the trap build checks them upstream.
        jr_aligned = jr_target & ~ADDR_W'(3);
        if (jr) begin
            pc_next = jr_aligned;
        end else if (branch && zero) begin
            pc_next = pc_plus4 + br_off;
        end else begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding fetch stage: REQ -> (WAIT) -> EXEC; optional IFU_MISALIGN_TRAP_EN adds HALT + misalign_err.
// Latency: instruction valid 1 cycle after ack; next fetch issued the cycle after EXEC with stall=0.
// Backpressure: imem_req held with stable address until imem_ack; stall freezes EXEC.
import mips_pkg::*;

module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch,
    input  logic               zero,
    input  logic               jr,
    input  logic [ADDR_W-1:0]  jr_target,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               instr_valid
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic               misalign_err
`endif
);

    ifu_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_next;
`ifdef IFU_MISALIGN_TRAP_EN
    logic                misalign_q, misalign_d;
`endif

    pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_logic (
        .pc        (pc_q),
        .imm       (get_imm(instr_q)),
        .branch    (branch),
        .zero      (zero),
        .jr        (jr),
        .jr_target (jr_target),
        .pc_plus4  (pc_plus4),
        .pc_next   (pc_next)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef IFU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            REQ, WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end else begin
                    state_d = WAIT;
                end
            end
            EXEC: begin
                if (!stall) begin
`ifdef IFU_MISALIGN_TRAP_EN
                    if (jr && (jr_target[1:0] != 2'b00)) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = REQ;
                    end
`else
                    pc_d    = pc_next;
                    state_d = REQ;
`endif
                end
            end
`ifdef IFU_MISALIGN_TRAP_EN
            HALT: state_d = HALT;
`endif
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef IFU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Outputs are gated by rst so the reset cycle never presents a request.
    assign imem_req    = ((state_q == REQ) || (state_q == WAIT)) && !rst;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == EXEC) && !rst;
    assign instr       = instr_q;
    assign opcode      = get_opcode(instr_q);
    assign funct       = get_funct(instr_q);
`ifdef IFU_MISALIGN_TRAP_EN
    assign misalign_err = misalign_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the control unit in the single-cycle MIPS core. It holds the PC and fetches from instruction memory over a req/ack handshake. It presents opcode/funct and the full instruction word to decode, then computes the next PC from the branch/zero/jr feedback.
One instruction is in flight at a time; no pipelining.

Parameters:
ADDR_W, 32, PC and memory address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address (= pc), word aligned
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
stall  in  1  hold current instruction; no PC update
branch  in  1  from control unit: current instr is beq
zero  in  1  from ALU: operands equal
jr  in  1  from control unit: current instr is jr
jr_target  in  ADDR_W  rs register value for jr
instr  out  32  latched instruction word
opcode  out  6  instr[31:26], to control unit
funct  out  6  instr[5:0], to control unit
pc_plus4  out  ADDR_W  pc + 4 of current instr
instr_valid  out  1  instr/opcode/funct valid for decode

Behaviour:
- Only one clock and one reset are used. Reset is synchronous and active-high: on the rising edge of clk with rst=1, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, state=REQ. rst overrides every other input.
- FSM states: REQ, WAIT, EXEC.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ack=1 in the same cycle: latch imem_rdata into instr; go to EXEC.
  - Otherwise go to WAIT.
- WAIT: imem_req stays 1 with imem_addr stable. On imem_ack, latch imem_rdata and go to EXEC.
- EXEC: instr_valid=1 and imem_req=0.
  - stall=1: remain in EXEC; pc and instr held.
  - stall=0: update pc per the priority below, then go to REQ. The next instruction becomes valid at the earliest 2 cycles later: REQ with same-cycle ack, then EXEC.
- Next-PC priority, evaluated only in EXEC with stall=0:
  1. jr=1: pc = {jr_target[ADDR_W-1:2], 2'b00}.
  2. branch & zero: pc = pc_plus4 + (sext(instr[15:0]) << 2).
  3. else: pc = pc_plus4.
- jr and branch both asserted: jr wins.
- All PC arithmetic is modulo 2^ADDR_W. pc=32'hFFFF_FFFC wraps to 0 with no flag.
- imem_ack outside REQ/WAIT is ignored.
- Reset asserted during WAIT abandons the outstanding fetch. An ack arriving in the reset cycle is discarded.
- opcode, funct and pc_plus4 are combinational from instr/pc. They are meaningful only when instr_valid=1.

Optional Feature:
IFU_MISALIGN_TRAP_EN
- Defined: adds output port misalign_err (1 bit, reset 0). In EXEC with stall=0, jr=1 and jr_target[1:0]!=0: misalign_err sets (sticky), the FSM enters HALT (imem_req=0, instr_valid=0), and pc is unchanged. Only rst exits HALT.
- Undefined: no misalign_err port and no HALT state. Target low bits are silently cleared.

Decomposition:
- Shared package mips_pkg holds: OPCODE/FUNCT field bit positions, opcode constants (R-type 000000, beq 000100, lw 100011, sw 101011, addi 001000, andi 001100), the ifu_state_t enum {REQ, WAIT, EXEC, HALT}, and INSTR_W=32.
- One sub-module, pc_next_logic: combinational next-PC select and adder (pc, instr imm, branch, zero, jr, jr_target -> pc_next).

Test Plan:
- Reset then memory acks in the same cycle with 32'h0000_0020 (add) -> imem_addr=0, then instr_valid=1, opcode=0, funct=6'h20, pc_plus4=4; next fetch at 4.
- Memory acks after 3 wait cycles -> imem_req held 1 and imem_addr stable for 4 cycles; instr latched exactly on the ack cycle.
- beq at pc=8 with imm=16'hFFFE: zero=1 -> next imem_addr=4; zero=0 -> next imem_addr=12.
- jr=1 and branch=1 together with jr_target=32'h100 -> next imem_addr=32'h100.
- stall=1 for 5 cycles in EXEC -> instr, pc and instr_valid held and no imem_req; after stall=0, one PC update.
- rst asserted in WAIT with ack the same cycle -> instr stays 0 and the next request is at RESET_PC. With IFU_MISALIGN_TRAP_EN, jr_target=32'h102 -> misalign_err=1 and no further imem_req.
